sort_result_reader: RTL and testbench
=====================================

Name: sort_result_reader

Overview:
- Reader side of the sort memory: once the sorting machine signals completion, this block walks the sorted array RAM, one word at a time, over its synchronous read port.
- Each word and its index go to the DE1-SoC HEX displays.
- Stepping is manual (push button) or automatic (timed scan).
- During the first pass after completion it checks that the array is in ascending order and flags any violation.

Parameters:
DEPTH, 16, number of words in the sorted array (power of 2)
AW, 4, address width, log2(DEPTH), max 4 (one HEX digit)
DW, 8, data word width, max 8 (two HEX digits)
SCAN_TICKS, 25000000, SHOW-state dwell in CLOCK_50 cycles in auto mode (0.5 s)

Ports:
CLOCK_50  input  1  system clock, 50 MHz
rst  input  1  asynchronous reset, active-high
sort_done  input  1  level; high while the sorted array in RAM is stable and readable
step  input  1  raw asynchronous button, active-high; advance one word per rising edge
auto_scan  input  1  level; 1 = advance every SCAN_TICKS cycles, and step is ignored
rd_en  output  1  RAM read strobe
rd_addr  output  AW  RAM read address
rd_data  input  DW  RAM read data; valid the cycle after rd_en
disp_value  output  DW  currently displayed word
disp_index  output  AW  address of the displayed word
valid  output  1  disp_value/disp_index hold a fetched word
pass_done  output  1  sticky; one full pass of DEPTH words completed
order_err  output  1  sticky; a descending pair was found in the first pass
HEX0  output  7  seven-segment, active-low, disp_value[3:0]
HEX1  output  7  seven-segment, active-low, disp_value[7:4]
HEX2  output  7  seven-segment, active-low, disp_index[3:0]

Behaviour:
- Reset (asynchronous, rst=1):
  - State IDLE.
  - rd_en=0, rd_addr=0, disp_value=0, disp_index=0.
  - valid=0, pass_done=0, order_err=0.
  - Scan counter 0, synchroniser flops 0.
  - HEX0..HEX2 blank (7'h7F).
  - A reset mid-operation aborts any read immediately.
- step passes through a 2-flop synchroniser and then a rising-edge detector. step_pulse is one cycle wide and occurs 2 cycles after the input rises.
- FSM states: IDLE, FETCH, CAPTURE, SHOW.
  - IDLE: wait for sort_done=1, then go to FETCH with rd_addr=0.
  - FETCH: rd_en=1 for exactly this one cycle at rd_addr; go to CAPTURE.
  - CAPTURE: register rd_data into disp_value and rd_addr into disp_index; set valid=1; run the order check; go to SHOW. The new display values are visible from the first SHOW cycle.
  - SHOW: hold the display. The advance condition is:
    - step_pulse when auto_scan=0, or
    - scan counter reaching SCAN_TICKS-1 when auto_scan=1.
    On advance, rd_addr <= rd_addr+1, wrapping from DEPTH-1 to 0, and the next state is FETCH.
  - Latency from advance to new display: 3 cycles (SHOW, then FETCH, then CAPTURE, then SHOW updated).
- Scan counter:
  - Clears on every entry to SHOW, and whenever auto_scan=0.
  - Toggling auto_scan mid-dwell restarts the dwell.
- Wrap-around: the advance from DEPTH-1 to 0 sets pass_done. pass_done stays 1 until sort_done falls or reset.
- Order check:
  - Active only before pass_done is set.
  - For index>0, compare the captured value with the previous captured value, unsigned. If new < previous, set order_err.
  - Equal values are legal.
  - order_err is sticky until sort_done falls or reset.
- sort_done falling in any state:
  - Next state is IDLE.
  - valid=0, rd_en=0 next cycle, rd_addr=0.
  - pass_done and order_err clear.
  - HEX blank.
  - A read in flight is discarded.
- sort_done rising again restarts from index 0.
- A step_pulse outside SHOW is dropped; it is not queued.
- HEX outputs:
  - Combinational decode of the 0-F glyphs, active-low: 0 = 7'b1000000, F = 7'b0001110.
  - All HEX outputs show blank while valid=0.
  - Digits beyond DW/AW are zero-extended.

Test Plan:
1. RAM = {3,5,5,9,...,0xF0} ascending, sort_done=1, auto_scan=0:
   - Required: rd_en pulses once, and 3 cycles after sort_done rises disp_value=0x03, disp_index=0, valid=1.
   - Then, after each step press, the display moves to 0x05, 0x05, 0x09 in order, and order_err stays 0.
2. RAM[6]=0x40, RAM[7]=0x3F, step through all 16 words -> order_err=1 after index 7 is captured. It stays 1 through the wrap back to index 0, and pass_done=1 after the wrap.
3. auto_scan=1, SCAN_TICKS=4 (sim) -> a new index every 7 cycles (4 dwell + 3 fetch). After index 15 comes index 0, and pass_done=1.
4. sort_done drops while the FSM is in CAPTURE -> next cycle IDLE, valid=0, HEX0..HEX2=7'h7F, pass_done=0, order_err=0. On sort_done rising again, disp_index=0.
5. step pulses 1 cycle wide and glitches shorter than the clock period -> at most one advance per sampled rising edge. Holding step high for 100 cycles gives exactly one advance.
6. Assert rst for 1 cycle mid-SHOW at index 9 -> all outputs reach their reset values asynchronously. After release with sort_done=1, the display restarts at index 0.

Source files
------------

// File: rtl/sort_result_reader.sv
// rtl/sort_result_reader.sv - walks the sorted RAM, shows word/index on HEX, checks ascending order
module sort_result_reader #(
   parameter int DEPTH      = 16,
   parameter int AW         = 4,
   parameter int DW         = 8,
   parameter int SCAN_TICKS = 25000000
) (
   input  logic          CLOCK_50,
   input  logic          rst,
   input  logic          sort_done,
   input  logic          step,
   input  logic          auto_scan,
   output logic          rd_en,
   output logic [AW-1:0] rd_addr,
   input  logic [DW-1:0] rd_data,
   output logic [DW-1:0] disp_value,
   output logic [AW-1:0] disp_index,
   output logic          valid,
   output logic          pass_done,
   output logic          order_err,
   output logic [6:0]    HEX0,
   output logic [6:0]    HEX1,
   output logic [6:0]    HEX2
);

   localparam int CW = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
   localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_TICKS - 1);
   localparam logic [AW-1:0] ADDR_LAST = AW'(DEPTH - 1);

   typedef enum logic [1:0] {IDLE, FETCH, CAPTURE, SHOW} state_t;

   state_t        state;
   state_t        state_nxt;
   logic          step_s1;
   logic          step_s2;
   logic          step_d;
   logic          step_pulse;
   logic [CW-1:0] scan_cnt;
   logic          scan_hit;
   logic          advance;
   logic [7:0]    val_ext;
   logic [3:0]    idx_ext;

   function automatic logic [6:0] seg7(input logic [3:0] d);
      case (d)
         4'h0: seg7 = 7'b1000000;
         4'h1: seg7 = 7'b1111001;
         4'h2: seg7 = 7'b0100100;
         4'h3: seg7 = 7'b0110000;
         4'h4: seg7 = 7'b0011001;
         4'h5: seg7 = 7'b0010010;
         4'h6: seg7 = 7'b0000010;
         4'h7: seg7 = 7'b1111000;
         4'h8: seg7 = 7'b0000000;
         4'h9: seg7 = 7'b0010000;
         4'hA: seg7 = 7'b0001000;
         4'hB: seg7 = 7'b0000011;
         4'hC: seg7 = 7'b1000110;
         4'hD: seg7 = 7'b0100001;
         4'hE: seg7 = 7'b0000110;
         default: seg7 = 7'b0001110;
      endcase
   endfunction

   // Two-flop synchroniser for the raw button plus a delayed copy for edge detection
   always_ff @(posedge CLOCK_50 or posedge rst) begin
      if (rst) begin
         step_s1 <= 1'b0;
         step_s2 <= 1'b0;
         step_d  <= 1'b0;
      end else begin
         step_s1 <= step;
         step_s2 <= step_s1;
         step_d  <= step_s2;
      end
   end

   assign step_pulse = step_s2 & ~step_d;
   assign advance    = (state == SHOW) && (auto_scan ? scan_hit : step_pulse);

   // Dwell counter: only runs in SHOW with auto_scan; the hit is registered so the
   // dwell is SCAN_TICKS counted cycles followed by the advancing cycle
   always_ff @(posedge CLOCK_50 or posedge rst) begin
      if (rst) begin
         scan_cnt <= '0;
         scan_hit <= 1'b0;
      end else if (state != SHOW || !auto_scan) begin
         scan_cnt <= '0;
         scan_hit <= 1'b0;
      end else begin
         scan_hit <= (scan_cnt == SCAN_LAST);
         if (scan_cnt != SCAN_LAST) scan_cnt <= scan_cnt + 1'b1;
      end
   end

   // State register
   always_ff @(posedge CLOCK_50 or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic; losing sort_done aborts from any state
   always_comb begin
      state_nxt = state;
      if (!sort_done) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE:    state_nxt = FETCH;
            FETCH:   state_nxt = CAPTURE;
            CAPTURE: state_nxt = SHOW;
            SHOW:    if (advance) state_nxt = FETCH;
            default: state_nxt = IDLE;
         endcase
      end
   end

   // Address walk, display capture, pass tracking and first-pass order check
   always_ff @(posedge CLOCK_50 or posedge rst) begin
      if (rst) begin
         rd_addr    <= '0;
         disp_value <= '0;
         disp_index <= '0;
         valid      <= 1'b0;
         pass_done  <= 1'b0;
         order_err  <= 1'b0;
      end else if (!sort_done) begin
         rd_addr   <= '0;
         valid     <= 1'b0;
         pass_done <= 1'b0;
         order_err <= 1'b0;
      end else begin
         case (state)
            IDLE: rd_addr <= '0;
            CAPTURE: begin
               disp_value <= rd_data;
               disp_index <= rd_addr;
               valid      <= 1'b1;
               if (!pass_done && rd_addr != '0 && rd_data < disp_value) order_err <= 1'b1;
            end
            SHOW: begin
               if (advance) begin
                  if (rd_addr == ADDR_LAST) begin
                     rd_addr   <= '0;
                     pass_done <= 1'b1;
                  end else begin
                     rd_addr <= rd_addr + 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign val_ext = 8'(disp_value);
   assign idx_ext = 4'(disp_index);

   // Outputs: read strobe from state, HEX glyphs blanked until a word is held
   always_comb begin
      rd_en = (state == FETCH);
      HEX0  = 7'h7F;
      HEX1  = 7'h7F;
      HEX2  = 7'h7F;
      if (valid) begin
         HEX0 = seg7(val_ext[3:0]);
         HEX1 = seg7(val_ext[7:4]);
         HEX2 = seg7(idx_ext);
      end
   end

endmodule

// File: tb/tb_sort_result_reader.sv
// tb/tb_sort_result_reader.sv - self-checking bench for sort_result_reader
module tb_sort_result_reader;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       sort_done = 1'b0;
   logic       step = 1'b0;
   logic       auto_scan = 1'b0;
   logic       rd_en;
   logic [3:0] rd_addr;
   logic [7:0] rd_data;
   logic [7:0] disp_value;
   logic [3:0] disp_index;
   logic       valid;
   logic       pass_done;
   logic       order_err;
   logic [6:0] HEX0;
   logic [6:0] HEX1;
   logic [6:0] HEX2;

   logic [7:0] ram [16];
   int         checks = 0;
   int         errors = 0;
   int         rd_cnt = 0;

   typedef struct {
      bit restart;
      int sel;
      int presses;
      int val;
      int idx;
      bit err;
      bit pass;
   } vec_t;

   vec_t tbl [9];

   sort_result_reader #(.DEPTH(16), .AW(4), .DW(8), .SCAN_TICKS(4)) dut (
      .CLOCK_50(clk), .rst(rst), .sort_done(sort_done), .step(step), .auto_scan(auto_scan),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
      .disp_value(disp_value), .disp_index(disp_index), .valid(valid),
      .pass_done(pass_done), .order_err(order_err),
      .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2));

   always #5 clk = ~clk;

   // synchronous-read RAM model
   always @(posedge clk) if (rd_en) rd_data <= ram[rd_addr];

   always @(negedge clk) if (rd_en) rd_cnt++;

   function automatic logic [6:0] seg(input int d);
      case (d & 15)
         0: seg = 7'h40;  1: seg = 7'h79;  2: seg = 7'h24;  3: seg = 7'h30;
         4: seg = 7'h19;  5: seg = 7'h12;  6: seg = 7'h02;  7: seg = 7'h78;
         8: seg = 7'h00;  9: seg = 7'h10;  10: seg = 7'h08; 11: seg = 7'h03;
         12: seg = 7'h46; 13: seg = 7'h21; 14: seg = 7'h06; default: seg = 7'h0E;
      endcase
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic press();
      step = 1'b1;
      tick(1);
      step = 1'b0;
      tick(7);
   endtask

   task automatic load_ram(input int sel);
      int base [16] = '{'h03, 'h05, 'h05, 'h09, 'h10, 'h20, 'h30, 'h40,
                        'h50, 'h60, 'h70, 'h80, 'h90, 'hA0, 'hC0, 'hF0};
      for (int i = 0; i < 16; i++) ram[i] = 8'(base[i]);
      if (sel == 1) begin
         ram[6] = 8'h40;
         ram[7] = 8'h3F;
      end
   endtask

   task automatic restart(input int sel);
      sort_done = 1'b0;
      tick(2);
      if (sel >= 0) load_ram(sel);
      sort_done = 1'b1;
      tick(3);
   endtask

   task automatic chk_display(input string tag, input int idx, input int val);
      chk({tag, "_valid"}, valid, 1);
      chk({tag, "_index"}, disp_index, idx);
      chk({tag, "_value"}, disp_value, val);
      chk({tag, "_hex0"}, HEX0, seg(val));
      chk({tag, "_hex1"}, HEX1, seg(val >> 4));
      chk({tag, "_hex2"}, HEX2, seg(idx));
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_rd_en"}, rd_en, 0);
      chk({tag, "_rd_addr"}, rd_addr, 0);
      chk({tag, "_value"}, disp_value, 0);
      chk({tag, "_index"}, disp_index, 0);
      chk({tag, "_valid"}, valid, 0);
      chk({tag, "_pass"}, pass_done, 0);
      chk({tag, "_err"}, order_err, 0);
      chk({tag, "_hex0"}, HEX0, 'h7F);
      chk({tag, "_hex1"}, HEX1, 'h7F);
      chk({tag, "_hex2"}, HEX2, 'h7F);
   endtask

   initial begin
      int rc0;
      int n;
      int last;
      int t_last;
      int changes;
      bit wrapped;
      int k;
      int lim;
      bit exp_err;

      tbl[0] = '{0, 0, 1, 'h05, 1, 0, 0};
      tbl[1] = '{0, 0, 1, 'h05, 2, 0, 0};
      tbl[2] = '{0, 0, 1, 'h09, 3, 0, 0};
      tbl[3] = '{1, 1, 0, 'h03, 0, 0, 0};
      tbl[4] = '{0, 0, 6, 'h40, 6, 0, 0};
      tbl[5] = '{0, 0, 1, 'h3F, 7, 1, 0};
      tbl[6] = '{0, 0, 8, 'hF0, 15, 1, 0};
      tbl[7] = '{0, 0, 1, 'h03, 0, 1, 1};
      tbl[8] = '{0, 0, 1, 'h05, 1, 1, 1};

      // reset state, observed before any clock edge
      load_ram(0);
      #2;
      chk_reset_outputs("reset");
      tick(2);
      rst = 1'b0;
      tick(1);

      // exact start-up latency after sort_done rises
      rc0 = rd_cnt;
      sort_done = 1'b1;
      tick(1);
      chk("t1_fetch_rd_en", rd_en, 1);
      chk("t1_fetch_addr", rd_addr, 0);
      chk("t1_fetch_valid", valid, 0);
      tick(1);
      chk("t1_capture_rd_en", rd_en, 0);
      chk("t1_capture_valid", valid, 0);
      tick(1);
      chk_display("t1_first", 0, 'h03);
      chk("t1_rd_pulses", rd_cnt - rc0, 1);

      // table: stepping, order violation, wrap
      for (int v = 0; v < 9; v++) begin
         rc0 = rd_cnt;
         if (tbl[v].restart) restart(tbl[v].sel);
         for (int p = 0; p < tbl[v].presses; p++) press();
         chk_display($sformatf("tbl%0d", v), tbl[v].idx, tbl[v].val);
         chk($sformatf("tbl%0d_err", v), order_err, tbl[v].err);
         chk($sformatf("tbl%0d_pass", v), pass_done, tbl[v].pass);
         chk($sformatf("tbl%0d_reads", v), rd_cnt - rc0, tbl[v].restart ? 1 : tbl[v].presses);
      end

      // sort_done falls during CAPTURE
      step = 1'b1;
      tick(1);
      step = 1'b0;
      n = 0;
      while (!rd_en && n < 10) begin
         tick(1);
         n++;
      end
      chk("t4_fetch_seen", rd_en, 1);
      tick(1);
      sort_done = 1'b0;
      tick(1);
      chk("t4_valid", valid, 0);
      chk("t4_rd_en", rd_en, 0);
      chk("t4_rd_addr", rd_addr, 0);
      chk("t4_pass", pass_done, 0);
      chk("t4_err", order_err, 0);
      chk("t4_hex0", HEX0, 'h7F);
      chk("t4_hex1", HEX1, 'h7F);
      chk("t4_hex2", HEX2, 'h7F);
      sort_done = 1'b1;
      tick(3);
      chk_display("t4_restart", 0, ram[0]);

      // auto scan with SCAN_TICKS=4: one new index every 7 cycles
      restart(0);
      auto_scan = 1'b1;
      last = disp_index;
      t_last = 0;
      changes = 0;
      wrapped = 0;
      for (int c = 1; c <= 200 && changes < 18; c++) begin
         tick(1);
         if (disp_index != 4'(last)) begin
            changes++;
            if (changes > 1) chk("t3_period", c - t_last, 7);
            chk("t3_index", disp_index, (last + 1) % 16);
            chk("t3_value", disp_value, ram[(last + 1) % 16]);
            if (disp_index == 0) wrapped = 1;
            chk("t3_pass", pass_done, wrapped);
            last = disp_index;
            t_last = c;
         end
      end
      chk("t3_changes", changes, 18);
      auto_scan = 1'b0;

      // glitches and a long press
      restart(0);
      #2 step = 1'b1;
      #3 step = 1'b0;
      tick(10);
      chk("t5_short_glitch", disp_index, 0);
      #7 step = 1'b1;
      #4 step = 1'b0;
      tick(10);
      chk("t5_edge_glitch", disp_index, 1);
      step = 1'b1;
      tick(20);
      chk("t5_hold_mid", disp_index, 2);
      tick(80);
      step = 1'b0;
      tick(10);
      chk("t5_hold_end", disp_index, 2);

      // randomized RAM contents and press counts against the reference model
      for (int r = 0; r < 4; r++) begin
         n = $urandom_range(0, 15);
         for (int i = 0; i < 16; i++) begin
            if (r % 2 == 0) begin
               ram[i] = 8'(n);
               n += $urandom_range(0, 15);
            end else begin
               ram[i] = 8'($urandom_range(0, 255));
            end
         end
         restart(-1);
         chk_display($sformatf("rnd%0d_start", r), 0, ram[0]);
         k = 0;
         while (k < 20) begin
            n = $urandom_range(1, 3);
            for (int p = 0; p < n; p++) press();
            k += n;
            lim = (k < 15) ? k : 15;
            exp_err = 0;
            for (int i = 1; i <= lim; i++) if (ram[i] < ram[i-1]) exp_err = 1;
            chk($sformatf("rnd%0d_index", r), disp_index, k % 16);
            chk($sformatf("rnd%0d_value", r), disp_value, ram[k % 16]);
            chk($sformatf("rnd%0d_err", r), order_err, exp_err);
            chk($sformatf("rnd%0d_pass", r), pass_done, (k >= 16) ? 1 : 0);
         end
      end

      // asynchronous reset mid-SHOW at index 9
      restart(0);
      for (int p = 0; p < 9; p++) press();
      chk("t6_before", disp_index, 9);
      #2 rst = 1'b1;
      #1;
      chk_reset_outputs("t6_async");
      tick(1);
      rst = 1'b0;
      tick(3);
      chk_display("t6_restart", 0, 'h03);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
